// File: rtl/wb_stage.sv
// Write-back stage: selects one of NSRC result sources or extracts load data,
// and registers it into a single-cycle register-file write port with forwarding.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int NSRC  = 4,
    parameter int RA_W  = 5,
    parameter int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic [NSRC*XLEN-1:0] in_src,
    input  logic [RA_W-1:0]      in_rd,
    input  logic                 in_wr,
    input  logic                 in_is_load,
    input  logic [1:0]           in_ld_size,
    input  logic                 in_ld_uns,
    input  logic [2:0]           in_ld_off,
    input  logic                 mem_rvalid,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic                 rf_wr_en,
    output logic [RA_W-1:0]      rf_wr_addr,
    output logic [XLEN-1:0]      rf_wr_data,
    input  logic [RA_W-1:0]      fwd_addr_a,
    input  logic [RA_W-1:0]      fwd_addr_b,
    output logic                 fwd_hit_a,
    output logic                 fwd_hit_b,
    output logic [XLEN-1:0]      fwd_data_a,
    output logic [XLEN-1:0]      fwd_data_b,
    output logic                 ld_pending,
    output logic [RA_W-1:0]      ld_rd
);

    // state    | meaning
    // IDLE     | accepting results from execute
    // WAIT_MEM | load accepted, holding until mem_rvalid
    typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

    localparam int NBYTES = XLEN / 8;

    state_t          r_state;
    logic            r_wr_en;
    logic [RA_W-1:0] r_wr_addr;
    logic [XLEN-1:0] r_wr_data;
    logic            r_ld_pending;
    logic [RA_W-1:0] r_ld_rd;
    logic            r_ld_wr;
    logic [1:0]      r_ld_size;
    logic            r_ld_uns;
    logic [2:0]      r_ld_off;

    logic            w_ready;
    logic            w_accept;
    logic [XLEN-1:0] w_src_data;
    logic [2:0]      w_boff;
    logic [2:0]      w_boff_m;
    logic [XLEN-1:0] w_shifted;
    logic            w_fill;
    int              w_lane_w;
    logic [XLEN-1:0] w_ld_data;

    assign w_ready  = enable && (r_state == IDLE);
    assign w_accept = in_valid && w_ready;

    // Out-of-range selects fall through to slot 0.
    always_comb begin
        w_src_data = in_src[0 +: XLEN];
        for (int k = 1; k < NSRC; k++) begin
            if (in_sel == SEL_W'(k)) begin
                w_src_data = in_src[k*XLEN +: XLEN];
            end
        end
    end

    // Byte offset of the lane, aligned to the access size and wrapped to the word.
    always_comb begin
        case (r_ld_size)
            2'd0:    w_boff = r_ld_off;
            2'd1:    w_boff = {r_ld_off[2:1], 1'b0};
            2'd2:    w_boff = {r_ld_off[2], 2'b00};
            default: w_boff = 3'd0;
        endcase
        w_boff_m  = w_boff & 3'(NBYTES - 1);
        w_shifted = mem_rdata >> {w_boff_m, 3'b000};
    end

    always_comb begin
        case (r_ld_size)
            2'd0: begin
                w_lane_w = 8;
                w_fill   = !r_ld_uns && w_shifted[7];
            end
            2'd1: begin
                w_lane_w = 16;
                w_fill   = !r_ld_uns && w_shifted[15];
            end
            2'd2: begin
                w_lane_w = 32;
                w_fill   = !r_ld_uns && w_shifted[31];
            end
            default: begin
                w_lane_w = (XLEN > 32) ? XLEN : 32;
                w_fill   = !r_ld_uns && w_shifted[XLEN-1];
            end
        endcase
        w_ld_data = w_shifted;
        for (int i = 0; i < XLEN; i++) begin
            if (i >= w_lane_w) begin
                w_ld_data[i] = w_fill;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_ld_pending <= 1'b0;
            r_ld_rd      <= '0;
            r_ld_wr      <= 1'b0;
            r_ld_size    <= '0;
            r_ld_uns     <= 1'b0;
            r_ld_off     <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (in_is_load) begin
                            r_state      <= WAIT_MEM;
                            r_ld_pending <= 1'b1;
                            r_ld_rd      <= in_rd;
                            r_ld_wr      <= in_wr;
                            r_ld_size    <= in_ld_size;
                            r_ld_uns     <= in_ld_uns;
                            r_ld_off     <= in_ld_off;
                        end else begin
                            r_wr_en   <= in_wr && (in_rd != '0);
                            r_wr_addr <= in_rd;
                            r_wr_data <= w_src_data;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid) begin
                        r_state      <= IDLE;
                        r_ld_pending <= 1'b0;
                        r_wr_en      <= r_ld_wr && (r_ld_rd != '0);
                        r_wr_addr    <= r_ld_rd;
                        r_wr_data    <= w_ld_data;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready   = w_ready;
    assign rf_wr_en   = r_wr_en;
    assign rf_wr_addr = r_wr_addr;
    assign rf_wr_data = r_wr_data;
    assign ld_pending = r_ld_pending;
    assign ld_rd      = r_ld_rd;

    // A pending load is never forwarded; decode stalls on ld_pending/ld_rd instead.
    assign fwd_hit_a  = r_wr_en && (fwd_addr_a == r_wr_addr) && (fwd_addr_a != '0);
    assign fwd_hit_b  = r_wr_en && (fwd_addr_b == r_wr_addr) && (fwd_addr_b != '0);
    assign fwd_data_a = fwd_hit_a ? r_wr_data : '0;
    assign fwd_data_b = fwd_hit_b ? r_wr_data : '0;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: two instances (NSRC=4 and NSRC=3) driven in lockstep and
// compared against a transaction-level model of the write-back behaviour.
module tb_wb_stage;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b1;
    logic         in_valid = 1'b0;
    logic [1:0]   in_sel = '0;
    logic [127:0] in_src = '0;
    logic [4:0]   in_rd = '0;
    logic         in_wr = 1'b0;
    logic         in_is_load = 1'b0;
    logic [1:0]   in_ld_size = '0;
    logic         in_ld_uns = 1'b0;
    logic [2:0]   in_ld_off = '0;
    logic         mem_rvalid = 1'b0;
    logic [31:0]  mem_rdata = '0;
    logic [4:0]   fwd_addr_a = '0;
    logic [4:0]   fwd_addr_b = '0;

    logic        o4_ready, o4_wr_en, o4_hit_a, o4_hit_b, o4_pend;
    logic [4:0]  o4_wr_addr, o4_ld_rd;
    logic [31:0] o4_wr_data, o4_fd_a, o4_fd_b;
    logic        o3_ready, o3_wr_en, o3_hit_a, o3_hit_b, o3_pend;
    logic [4:0]  o3_wr_addr, o3_ld_rd;
    logic [31:0] o3_wr_data, o3_fd_a, o3_fd_b;

    int checks = 0;
    int failures = 0;

    // model state
    logic        m_pend = 1'b0;
    logic        m_wr = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [1:0]  m_size = '0;
    logic        m_uns = 1'b0;
    logic [2:0]  m_off = '0;
    logic        e_en = 1'b0;
    logic [4:0]  e_addr = '0;
    logic [31:0] e_d4 = '0;
    logic [31:0] e_d3 = '0;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32), .NSRC(4), .RA_W(5)) u_dut4 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(o4_ready),
        .in_sel(in_sel), .in_src(in_src), .in_rd(in_rd), .in_wr(in_wr),
        .in_is_load(in_is_load), .in_ld_size(in_ld_size), .in_ld_uns(in_ld_uns),
        .in_ld_off(in_ld_off), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_wr_en(o4_wr_en), .rf_wr_addr(o4_wr_addr), .rf_wr_data(o4_wr_data),
        .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b), .fwd_hit_a(o4_hit_a),
        .fwd_hit_b(o4_hit_b), .fwd_data_a(o4_fd_a), .fwd_data_b(o4_fd_b),
        .ld_pending(o4_pend), .ld_rd(o4_ld_rd)
    );

    wb_stage #(.XLEN(32), .NSRC(3), .RA_W(5)) u_dut3 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(o3_ready),
        .in_sel(in_sel), .in_src(in_src[95:0]), .in_rd(in_rd), .in_wr(in_wr),
        .in_is_load(in_is_load), .in_ld_size(in_ld_size), .in_ld_uns(in_ld_uns),
        .in_ld_off(in_ld_off), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_wr_en(o3_wr_en), .rf_wr_addr(o3_wr_addr), .rf_wr_data(o3_wr_data),
        .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b), .fwd_hit_a(o3_hit_a),
        .fwd_hit_b(o3_hit_b), .fwd_data_a(o3_fd_a), .fwd_data_b(o3_fd_b),
        .ld_pending(o3_pend), .ld_rd(o3_ld_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] src_word(input int s);
        return in_src[s*32 +: 32];
    endfunction

    // Load result computed arithmetically from the lane/extension rules.
    function automatic logic [31:0] ld_model(input logic [31:0] rdata, input logic [1:0] sz,
                                             input logic uns, input logic [2:0] off);
        int unsigned v;
        int unsigned o;
        o = 32'(off);
        if (sz == 2'd0) begin
            v = (rdata >> (8 * (o % 4))) % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (rdata >> (16 * ((o / 2) % 2))) % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    task automatic fwd_chk(input logic [4:0] a);
        logic hit_a, hit_b;
        fwd_addr_a = a;
        fwd_addr_b = 5'($urandom);
        #1;
        hit_a = e_en && (a == e_addr) && (a != 5'd0);
        hit_b = e_en && (fwd_addr_b == e_addr) && (fwd_addr_b != 5'd0);
        chk("fwd_hit_a4", 32'(o4_hit_a), 32'(hit_a));
        chk("fwd_hit_b4", 32'(o4_hit_b), 32'(hit_b));
        chk("fwd_data_a4", o4_fd_a, hit_a ? e_d4 : 32'd0);
        chk("fwd_data_b4", o4_fd_b, hit_b ? e_d4 : 32'd0);
        chk("fwd_hit_a3", 32'(o3_hit_a), 32'(hit_a));
        chk("fwd_data_a3", o3_fd_a, hit_a ? e_d3 : 32'd0);
    endtask

    // Advance one clock: update the model from the current inputs, then check outputs.
    task automatic tick();
        logic acc;
        acc = in_valid && enable && !m_pend;
        e_en = 1'b0;
        if (reset) begin
            m_pend = 1'b0;
        end else if (m_pend) begin
            if (mem_rvalid) begin
                m_pend = 1'b0;
                e_en   = m_wr && (m_rd != 5'd0);
                e_addr = m_rd;
                e_d4   = ld_model(mem_rdata, m_size, m_uns, m_off);
                e_d3   = e_d4;
            end
        end else if (acc) begin
            if (in_is_load) begin
                m_pend = 1'b1;
                m_wr   = in_wr;
                m_rd   = in_rd;
                m_size = in_ld_size;
                m_uns  = in_ld_uns;
                m_off  = in_ld_off;
            end else begin
                e_en   = in_wr && (in_rd != 5'd0);
                e_addr = in_rd;
                e_d4   = src_word(int'(in_sel));
                e_d3   = src_word((in_sel < 2'd3) ? int'(in_sel) : 0);
            end
        end
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        chk("wr_en4", 32'(o4_wr_en), 32'(e_en));
        chk("wr_en3", 32'(o3_wr_en), 32'(e_en));
        if (e_en) begin
            chk("wr_addr4", 32'(o4_wr_addr), 32'(e_addr));
            chk("wr_data4", o4_wr_data, e_d4);
            chk("wr_data3", o3_wr_data, e_d3);
        end
        chk("ld_pending4", 32'(o4_pend), 32'(m_pend));
        chk("ld_pending3", 32'(o3_pend), 32'(m_pend));
        if (m_pend) chk("ld_rd4", 32'(o4_ld_rd), 32'(m_rd));
        chk("in_ready4", 32'(o4_ready), 32'(enable && !m_pend));
        chk("in_ready3", 32'(o3_ready), 32'(enable && !m_pend));
        fwd_chk(($urandom_range(1, 0) == 1) ? e_addr : 5'($urandom));
    endtask

    task automatic drive_alu(input logic [1:0] sel, input logic [4:0] rd, input logic wr);
        in_valid   = 1'b1;
        in_is_load = 1'b0;
        in_sel     = sel;
        in_rd      = rd;
        in_wr      = wr;
        in_src     = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic drive_load(input logic [1:0] sz, input logic uns, input logic [2:0] off,
                              input logic [4:0] rd);
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_wr      = 1'b1;
        in_rd      = rd;
        in_sel     = 2'($urandom);
        in_ld_size = sz;
        in_ld_uns  = uns;
        in_ld_off  = off;
    endtask

    task automatic load_with_delay(input logic [1:0] sz, input logic uns, input logic [2:0] off,
                                   input logic [31:0] rdata, input logic [31:0] exp);
        drive_load(sz, uns, off, 5'd9);
        tick();
        for (int i = 0; i < 3; i++) tick();
        mem_rdata  = rdata;
        mem_rvalid = 1'b1;
        tick();
        chk("ld_result", o4_wr_data, exp);
        chk("ld_addr", 32'(o4_wr_addr), 32'd9);
        tick();
    endtask

    initial begin
        // reset
        tick();
        tick();
        reset = 1'b0;
        chk("rst_wr_addr", 32'(o4_wr_addr), 32'd0);
        chk("rst_wr_data", o4_wr_data, 32'd0);
        chk("rst_ld_rd", 32'(o4_ld_rd), 32'd0);
        chk("rst_ready", 32'(o4_ready), 32'd1);

        // single ALU write, one-cycle pulse
        drive_alu(2'd1, 5'd5, 1'b1);
        in_src[63:32] = 32'hDEADBEEF;
        tick();
        chk("t1_data", o4_wr_data, 32'hDEADBEEF);
        chk("t1_addr", 32'(o4_wr_addr), 32'd5);
        tick();
        chk("t1_pulse_end", 32'(o4_wr_en), 32'd0);

        // back-to-back accepts; sel=3 is out of range for the NSRC=3 instance
        drive_alu(2'd0, 5'd1, 1'b1);
        tick();
        fwd_chk(5'd2);
        drive_alu(2'd2, 5'd2, 1'b1);
        tick();
        fwd_chk(5'd2);
        chk("b2b_hit2", 32'(o4_hit_a), 32'd1);
        drive_alu(2'd3, 5'd3, 1'b1);
        tick();
        fwd_chk(5'd2);
        chk("sel_oob3", o3_wr_data, src_word(0));
        tick();

        // loads with extension
        load_with_delay(2'd0, 1'b0, 3'd3, 32'h80112233, 32'hFFFFFF80);
        load_with_delay(2'd0, 1'b1, 3'd3, 32'h80112233, 32'h00000080);
        load_with_delay(2'd1, 1'b0, 3'd2, 32'h80112233, 32'hFFFF8011);
        load_with_delay(2'd2, 1'b0, 3'd4, 32'h80112233, 32'h80112233);

        // x0 write and x0 forwarding
        drive_alu(2'd1, 5'd0, 1'b1);
        tick();
        fwd_chk(5'd0);
        chk("x0_no_hit", 32'(o4_hit_a), 32'd0);

        // mem_rvalid while idle is ignored
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        tick();

        // reset mid-load with a coincident mem_rvalid
        drive_load(2'd2, 1'b0, 3'd0, 5'd12);
        tick();
        tick();
        reset      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        tick();
        reset = 1'b0;
        tick();
        chk("rst_mid_ready", 32'(o4_ready), 32'd1);
        chk("rst_mid_pend", 32'(o4_pend), 32'd0);

        // enable=0 during WAIT_MEM still completes the load, blocks new accepts
        drive_load(2'd0, 1'b1, 3'd1, 5'd14);
        tick();
        enable = 1'b0;
        drive_alu(2'd1, 5'd7, 1'b1);
        tick();
        drive_alu(2'd1, 5'd7, 1'b1);
        mem_rdata  = 32'h0000AB00;
        mem_rvalid = 1'b1;
        tick();
        chk("en0_ld_wr", 32'(o4_wr_en), 32'd1);
        chk("en0_ld_data", o4_wr_data, 32'h000000AB);
        drive_alu(2'd1, 5'd7, 1'b1);
        tick();
        chk("en0_blocked", 32'(o4_wr_en), 32'd0);
        enable = 1'b1;
        drive_alu(2'd1, 5'd7, 1'b1);
        tick();
        chk("en1_accept", 32'(o4_wr_addr), 32'd7);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            enable     = ($urandom_range(9, 0) != 0);
            in_valid   = ($urandom_range(1, 0) == 1);
            in_is_load = ($urandom_range(3, 0) == 0);
            in_sel     = 2'($urandom);
            in_src     = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_rd      = 5'($urandom);
            in_wr      = ($urandom_range(3, 0) != 0);
            in_ld_size = 2'($urandom);
            in_ld_uns  = ($urandom_range(1, 0) == 1);
            in_ld_off  = 3'($urandom);
            mem_rvalid = ($urandom_range(2, 0) == 0);
            mem_rdata  = $urandom();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
